cache_ctrl_16: RTL and testbench
================================

CACHE_CTRL_16 -- requirements
Module: cache_ctrl_16

Interface
REQ-001 Parameter TAG_W, default 23, meaning tag width; address = {tag[22:0], index[3:0], offset[4:0]}.
REQ-002 Parameter CNT_W, default 16, meaning width of hit/miss counters.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_read / mem_write  in  1 each  CPU request strobes, held until mem_resp.
REQ-006 mem_address  in  32  CPU byte address.
REQ-007 mem_resp  out  1  one-cycle CPU completion pulse.
REQ-008 tag_out  in  TAG_W  tag array read value at index.
REQ-009 valid_out, dirty_out  in  1 each  valid/dirty array read values at index.
REQ-010 index  out  4  set index driven to all 16-entry arrays.
REQ-011 load_data, load_tag, load_valid, load_dirty  out  1 each  array write enables.
REQ-012 dirty_in  out  1  value written to dirty array.
REQ-013 data_sel  out  1  0 = CPU byte-merge into line, 1 = line from pmem.
REQ-014 pmem_read / pmem_write  out  1 each  memory request strobes.
REQ-015 pmem_address  out  32  line-aligned memory address (offset bits 0).
REQ-016 pmem_resp  in  1  memory completion pulse.
REQ-017 hit_count / miss_count  out  CNT_W each  saturating statistics.

Function
REQ-018 FSM states SHALL be IDLE, CHECK, WRITEBACK, ALLOCATE.
REQ-019 IDLE: on mem_read or mem_write, latch mem_address and op type, go to CHECK; no outputs active.
REQ-020 mem_read and mem_write together SHALL be treated as write.
REQ-021 index SHALL always come from the latched address, never directly from mem_address.
REQ-022 hit = valid_out AND (tag_out == latched tag), evaluated in CHECK only.
REQ-023 CHECK hit read: mem_resp=1 for one cycle, to IDLE; hit latency = 2 cycles after request asserted in IDLE.
REQ-024 CHECK hit write: mem_resp=1, load_data=1, data_sel=0, load_dirty=1, dirty_in=1, to IDLE.
REQ-025 CHECK miss with valid_out AND dirty_out: to WRITEBACK; otherwise to ALLOCATE.
REQ-026 WRITEBACK: pmem_write=1, pmem_address={tag_out,index,5'b0}; on pmem_resp go to ALLOCATE.
REQ-027 ALLOCATE: pmem_read=1, pmem_address={latched tag,index,5'b0}; on pmem_resp assert load_data (data_sel=1), load_tag, load_valid, load_dirty with dirty_in=0, go to CHECK.
REQ-028 Re-entry to CHECK after ALLOCATE SHALL hit and complete per REQ-023/024.
REQ-029 pmem strobes SHALL be held continuously until pmem_resp; never both high.
REQ-030 hit_count increments once per request whose first CHECK hits; miss_count once per request whose first CHECK misses; re-entry CHECK counts nothing.
REQ-031 Counters SHALL saturate at all-ones, never wrap.
REQ-032 All outputs not listed active for a state SHALL be 0.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, counters 0, latched address 0, all strobes/enables/mem_resp 0, regardless of state mid-transaction.
REQ-034 After rst_n deasserts, first request SHALL be accepted on the next rising edge in IDLE.

Structure
REQ-035 Package cache_ctrl_pkg SHALL hold the state enum, TAG/INDEX/OFFSET width constants and address-field slice helpers.
REQ-036 Counters SHALL be a sub-module sat_counter (enable, clear-by-reset, CNT_W parameter), instantiated twice.
REQ-037 Array storage and data merge mux live outside this block; controller is state + strobes only.

Verification
REQ-038 Read 0x0000_0040 with valid=1, tag match -> mem_resp at cycle 2, no pmem activity, hit_count=1.
REQ-039 Write to index 3, valid=0 -> pmem_read address line-aligned, pmem_resp after 5 cycles -> load_tag/valid/data same cycle, then mem_resp with load_dirty=1, dirty_in=1; miss_count=1.
REQ-040 Read miss with dirty_out=1, tag_out=0x12 -> pmem_write at {0x12,index,0} first, then pmem_read at new tag, then mem_resp.
REQ-041 rst_n low during WRITEBACK -> pmem_write drops asynchronously, state IDLE, counters 0.
REQ-042 2^CNT_W+3 consecutive hits -> hit_count holds 0xFFFF.
REQ-043 mem_read and mem_write both high on hit -> treated as write (load_data=1).

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and address-field helpers for the 16-set cache controller.
// The address splits as {tag, index, offset}.
package cache_ctrl_pkg;

    localparam int ADDR_W   = 32;
    localparam int TAG_BITS = 23;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        ALLOCATE
    } state_e;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_BITS];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                                    input logic [INDEX_W-1:0]  idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl_16_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_ctrl_16.sv
// Direct-mapped, write-back cache controller for 16 sets: sequences tag check,
// dirty-line writeback and line allocation; the arrays themselves live outside.
module cache_ctrl_16
    import cache_ctrl_pkg::*;
#(
    parameter int TAG_W = 23,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    output logic              mem_resp,
    input  logic [TAG_W-1:0]  tag_out,
    input  logic              valid_out,
    input  logic              dirty_out,
    output logic [3:0]        index,
    output logic              load_data,
    output logic              load_tag,
    output logic              load_valid,
    output logic              load_dirty,
    output logic              dirty_in,
    output logic              data_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                first_q, first_d;
    logic                hit;
    logic                hit_en;
    logic                miss_en;
    logic                unused_offset;

    assign index         = addr_index(addr_q);
    assign hit           = valid_out && (tag_out == addr_tag(addr_q));
    assign unused_offset = ^addr_q[OFFSET_W-1:0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        first_d      = first_q;
        mem_resp     = 1'b0;
        load_data    = 1'b0;
        load_tag     = 1'b0;
        load_valid   = 1'b0;
        load_dirty   = 1'b0;
        dirty_in     = 1'b0;
        data_sel     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        hit_en       = 1'b0;
        miss_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = mem_address;
                    wr_d    = mem_write;
                    first_d = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Only the first look at a request feeds the statistics.
                first_d = 1'b0;
                if (hit) begin
                    mem_resp = 1'b1;
                    hit_en   = first_q;
                    if (wr_q) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    miss_en = first_q;
                    state_d = (valid_out && dirty_out) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = line_addr(tag_out, index);
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = line_addr(addr_tag(addr_q), index);
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    data_sel   = 1'b1;
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    load_dirty = 1'b1;
                    state_d    = CHECK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            first_q <= first_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hit_en),
        .count (hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (miss_en),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_ctrl_16.sv
// Directed bench for cache_ctrl_16 with a small tag/valid/dirty array model
// and a fixed-latency memory responder.
module tb_cache_ctrl_16;

    localparam int TAG_W  = 23;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [31:0]       mem_address = '0;
    logic              mem_resp;
    logic [TAG_W-1:0]  tag_out;
    logic              valid_out;
    logic              dirty_out;
    logic [3:0]        index;
    logic              load_data, load_tag, load_valid, load_dirty;
    logic              dirty_in, data_sel;
    logic              pmem_read, pmem_write;
    logic [31:0]       pmem_address;
    logic              pmem_resp;
    logic [CNT_W-1:0]  hit_count, miss_count;

    int errors = 0;
    int checks = 0;

    cache_ctrl_16 #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_resp     (mem_resp),
        .tag_out      (tag_out),
        .valid_out    (valid_out),
        .dirty_out    (dirty_out),
        .index        (index),
        .load_data    (load_data),
        .load_tag     (load_tag),
        .load_valid   (load_valid),
        .load_dirty   (load_dirty),
        .dirty_in     (dirty_in),
        .data_sel     (data_sel),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    // External array model
    logic [TAG_W-1:0] tag_mem   [16];
    logic             valid_mem [16];
    logic             dirty_mem [16];
    logic             pre_we = 1'b0;
    logic [3:0]       pre_idx = '0;
    logic [TAG_W-1:0] pre_tag = '0;
    logic             pre_v = 1'b0;
    logic             pre_d = 1'b0;

    assign tag_out   = tag_mem[index];
    assign valid_out = valid_mem[index];
    assign dirty_out = dirty_mem[index];

    always @(posedge clk) begin
        if (pre_we) begin
            tag_mem[pre_idx]   <= pre_tag;
            valid_mem[pre_idx] <= pre_v;
            dirty_mem[pre_idx] <= pre_d;
        end else begin
            if (load_tag)   tag_mem[index]   <= mem_address[31:9];
            if (load_valid) valid_mem[index] <= 1'b1;
            if (load_dirty) dirty_mem[index] <= dirty_in;
        end
    end

    // Memory responder: one-cycle pmem_resp after pmem_lat cycles of request
    int pmem_lat = 5;
    int pmem_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_resp <= 1'b0;
            pmem_cnt  <= 0;
        end else if ((pmem_read || pmem_write) && !pmem_resp) begin
            if (pmem_cnt == pmem_lat - 1) begin
                pmem_resp <= 1'b1;
                pmem_cnt  <= 0;
            end else begin
                pmem_cnt <= pmem_cnt + 1;
            end
        end else begin
            pmem_resp <= 1'b0;
        end
    end

    // Monitor: log pmem requests, allocate-completion strobes, strobe overlap
    logic [32:0] pmem_log [$];
    logic        prev_r = 1'b0;
    logic        prev_w = 1'b0;
    int          alloc_good = 0;
    int          both_high = 0;
    always @(negedge clk) begin
        prev_r <= pmem_read;
        prev_w <= pmem_write;
        if (pmem_read && !prev_r)  pmem_log.push_back({1'b0, pmem_address});
        if (pmem_write && !prev_w) pmem_log.push_back({1'b1, pmem_address});
        if (pmem_read && pmem_write) both_high <= both_high + 1;
        if (pmem_read && pmem_resp && load_data && data_sel && load_tag &&
            load_valid && load_dirty && !dirty_in)
            alloc_good <= alloc_good + 1;
    end

    int   cyc;
    logic r_load_data, r_load_dirty, r_dirty_in, r_data_sel, r_resp_after;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [TAG_W-1:0] t,
                           input logic v, input logic d);
        pre_we = 1'b1; pre_idx = idx; pre_tag = t; pre_v = v; pre_d = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr);
        cyc = 0;
        mem_read = rd; mem_write = wr; mem_address = addr;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (mem_resp) begin
                cyc = c;
                r_load_data  = load_data;
                r_load_dirty = load_dirty;
                r_dirty_in   = dirty_in;
                r_data_sel   = data_sel;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        checks++;
        if (cyc == 0) begin
            errors++;
            $display("FAIL req_timeout: addr=%h no mem_resp within 300 cycles", addr);
        end
        tick();
        r_resp_after = mem_resp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) preload(i[3:0], '0, 1'b0, 1'b0);
        #1;
        checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL rst_mem_resp: got %b want 0", mem_resp); end
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL rst_pmem: got %b want 00", {pmem_read, pmem_write}); end
        checks++; if ({load_data, load_tag, load_valid, load_dirty} !== 4'b0) begin errors++; $display("FAIL rst_loads: got %b want 0000", {load_data, load_tag, load_valid, load_dirty}); end
        checks++; if (hit_count !== '0 || miss_count !== '0) begin errors++; $display("FAIL rst_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
        checks++; if (index !== 4'd0) begin errors++; $display("FAIL rst_index: got %0d want 0", index); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_hit();
        preload(4'd2, 23'h0, 1'b1, 1'b0);
        pmem_log.delete();
        do_req(1'b1, 1'b0, 32'h0000_0040);
        checks++; if (cyc != 1) begin errors++; $display("FAIL hit_latency: got %0d want 1 edge after request", cyc); end
        checks++; if (r_resp_after !== 1'b0) begin errors++; $display("FAIL hit_resp_pulse: got %b want 0 next cycle", r_resp_after); end
        checks++; if (pmem_log.size() != 0) begin errors++; $display("FAIL hit_no_pmem: got %0d requests want 0", pmem_log.size()); end
        checks++; if (r_load_data !== 1'b0) begin errors++; $display("FAIL hit_read_load: got %b want 0", r_load_data); end
        checks++; if (hit_count !== 4'd1 || miss_count !== 4'd0) begin errors++; $display("FAIL hit_counts: got %0d/%0d want 1/0", hit_count, miss_count); end
    endtask

    task automatic test_write_miss_clean();
        preload(4'd3, 23'h0, 1'b0, 1'b0);
        pmem_log.delete();
        alloc_good = 0;
        pmem_lat = 5;
        do_req(1'b0, 1'b1, 32'h0000_AA64);
        checks++; if (cyc != 8) begin errors++; $display("FAIL wmiss_latency: got %0d want 8", cyc); end
        checks++;
        if (pmem_log.size() != 1 || pmem_log[0] !== {1'b0, 32'h0000_AA60}) begin
            errors++; $display("FAIL wmiss_pmem: got n=%0d first=%h want 1 read at 0000aa60", pmem_log.size(), (pmem_log.size() > 0) ? pmem_log[0] : 33'h0);
        end
        checks++; if (alloc_good != 1) begin errors++; $display("FAIL wmiss_alloc_strobes: got %0d want 1", alloc_good); end
        checks++;
        if ({r_load_data, r_data_sel, r_load_dirty, r_dirty_in} !== 4'b1011) begin
            errors++; $display("FAIL wmiss_write_strobes: got %b want 1011", {r_load_data, r_data_sel, r_load_dirty, r_dirty_in});
        end
        checks++; if (hit_count !== 4'd1 || miss_count !== 4'd1) begin errors++; $display("FAIL wmiss_counts: got %0d/%0d want 1/1", hit_count, miss_count); end
        checks++; if (dirty_mem[3] !== 1'b1 || tag_mem[3] !== 23'h55) begin errors++; $display("FAIL wmiss_array: got d=%b tag=%h want 1/55", dirty_mem[3], tag_mem[3]); end
    endtask

    task automatic test_dirty_writeback();
        preload(4'd5, 23'h12, 1'b1, 1'b1);
        pmem_log.delete();
        pmem_lat = 3;
        do_req(1'b1, 1'b0, 32'h0000_68A0);
        checks++;
        if (pmem_log.size() != 2 || pmem_log[0] !== {1'b1, 32'h0000_24A0} || pmem_log[1] !== {1'b0, 32'h0000_68A0}) begin
            errors++; $display("FAIL wb_order: got n=%0d want write 000024a0 then read 000068a0", pmem_log.size());
        end
        checks++; if (r_load_data !== 1'b0) begin errors++; $display("FAIL wb_read_load: got %b want 0", r_load_data); end
        checks++; if (hit_count !== 4'd1 || miss_count !== 4'd2) begin errors++; $display("FAIL wb_counts: got %0d/%0d want 1/2", hit_count, miss_count); end
        checks++; if (dirty_mem[5] !== 1'b0 || tag_mem[5] !== 23'h34) begin errors++; $display("FAIL wb_array: got d=%b tag=%h want 0/34", dirty_mem[5], tag_mem[5]); end
    endtask

    task automatic test_both_strobes();
        do_req(1'b1, 1'b1, 32'h0000_0044);
        checks++; if (cyc != 1) begin errors++; $display("FAIL both_latency: got %0d want 1", cyc); end
        checks++; if ({r_load_data, r_load_dirty, r_dirty_in} !== 3'b111) begin errors++; $display("FAIL both_as_write: got %b want 111", {r_load_data, r_load_dirty, r_dirty_in}); end
        checks++; if (hit_count !== 4'd2) begin errors++; $display("FAIL both_hit_count: got %0d want 2", hit_count); end
    endtask

    task automatic test_reset_mid_writeback();
        logic seen;
        preload(4'd7, 23'h1, 1'b1, 1'b1);
        pmem_lat = 50;
        seen = 1'b0;
        mem_read = 1'b1; mem_address = 32'h0000_04E0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (pmem_write) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rwb_enter: pmem_write never asserted"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL rwb_async_drop: got %b want 00", {pmem_read, pmem_write}); end
        checks++; if (hit_count !== '0 || miss_count !== '0) begin errors++; $display("FAIL rwb_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
        checks++; if (index !== 4'd0 || mem_resp !== 1'b0) begin errors++; $display("FAIL rwb_idle: got idx=%0d resp=%b want 0/0", index, mem_resp); end
        mem_read = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #3;
        pmem_lat = 5;
        do_req(1'b1, 1'b0, 32'h0000_0040);
        checks++; if (cyc != 1 || hit_count !== 4'd1) begin errors++; $display("FAIL rwb_first_req: got cyc=%0d hits=%0d want 1/1", cyc, hit_count); end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < (1 << CNT_W) - 2; i++) do_req(1'b1, 1'b0, 32'h0000_0040);
        checks++; if (hit_count !== 4'd14) begin errors++; $display("FAIL sat_pre: got %0d want 14", hit_count); end
        for (int i = 0; i < 5; i++) do_req(1'b1, 1'b0, 32'h0000_0040);
        checks++; if (hit_count !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h want f", hit_count); end
        checks++; if (miss_count !== 4'd0) begin errors++; $display("FAIL sat_miss: got %0d want 0", miss_count); end
    endtask

    initial begin
        tick();
        test_reset();
        test_read_hit();
        test_write_miss_clean();
        test_dirty_writeback();
        test_both_strobes();
        test_reset_mid_writeback();
        test_saturation();
        checks++; if (both_high != 0) begin errors++; $display("FAIL pmem_exclusive: got %0d overlap cycles want 0", both_high); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
